// File: rtl/key_pkg.sv
// Shared constants and types for the calculator key front end: key indices,
// default timing counts and the S2 press-classifier state encoding.
package key_pkg;

  localparam int NUM_KEYS  = 3;
  localparam int KEY_LEFT  = 0;
  localparam int KEY_MODE  = 1;
  localparam int KEY_RIGHT = 2;

  localparam int DEF_DEBOUNCE_CNT = 20;
  localparam int DEF_LONG_CNT     = 1000;
  localparam int DEF_REPEAT_DELAY = 500;
  localparam int DEF_REPEAT_CNT   = 150;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } s2_state_t;

endpackage

// File: rtl/key_conditioner_if.sv
// Pin-side and event-side signals of the key conditioner. The board/consumer
// side uses the master modport, the conditioner itself uses the slave modport.
interface key_conditioner_if;
  import key_pkg::*;

  logic [NUM_KEYS-1:0] key_raw;
  logic                btn_left;
  logic                btn_right;
  logic                s2_short;
  logic                s2_long;
  logic [NUM_KEYS-1:0] key_level;

  modport master (
    output key_raw,
    input  btn_left,
    input  btn_right,
    input  s2_short,
    input  s2_long,
    input  key_level
  );

  modport slave (
    input  key_raw,
    output btn_left,
    output btn_right,
    output s2_short,
    output s2_long,
    output key_level
  );

endinterface

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus debounce counter for a single push-button.
// The level only toggles after DEBOUNCE_CNT consecutive differing samples.
module key_debounce #(
  parameter int DEBOUNCE_CNT = 20
) (
  input  logic clk_db,
  input  logic rst_n,
  input  logic key_raw,
  output logic level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CNT);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             level_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk_db or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      level_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= key_raw;
      sync2_reg <= sync1_reg;
      // Any sample matching the current level restarts the run of differing samples.
      if (sync2_reg == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_W'(DEBOUNCE_CNT - 1)) begin
        level_reg <= ~level_reg;
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign level = level_reg;

endmodule

// File: rtl/key_conditioner.sv
// Debounces S0/S2/S3, classifies S2 presses as short/long and arbitrates the
// single-cycle events. Define KEY_AUTO_REPEAT_EN for left/right auto-repeat.
module key_conditioner
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT,
  parameter int LONG_CNT     = DEF_LONG_CNT,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_CNT   = DEF_REPEAT_CNT
) (
  input logic              clk_db,
  input logic              rst_n,
  key_conditioner_if.slave kif
);

  localparam int HOLD_W = $clog2(LONG_CNT + 1);

  logic [NUM_KEYS-1:0] level;
  logic [NUM_KEYS-1:0] level_prev_reg;
  logic [NUM_KEYS-1:0] rise;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      key_debounce #(
        .DEBOUNCE_CNT(DEBOUNCE_CNT)
      ) u_debounce (
        .clk_db (clk_db),
        .rst_n  (rst_n),
        .key_raw(kif.key_raw[gi]),
        .level  (level[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk_db or negedge rst_n) begin
    if (!rst_n) begin
      level_prev_reg <= '0;
    end else begin
      level_prev_reg <= level;
    end
  end

  assign rise = level & ~level_prev_reg;

  logic left_req;
  logic right_req;

`ifdef KEY_AUTO_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_CNT) ? REPEAT_DELAY : REPEAT_CNT;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [1:0] rep_fire;

  // Slot 0 serves the left key, slot 1 the right key; S2 never repeats.
  generate
    for (gi = 0; gi < 2; gi++) begin : g_repeat
      localparam int KI = (gi == 0) ? KEY_LEFT : KEY_RIGHT;

      logic [REP_W-1:0] rep_cnt_reg;
      logic             rep_first_reg;
      logic [REP_W-1:0] rep_cnt_inc;
      logic [REP_W-1:0] rep_target;

      assign rep_cnt_inc  = rep_cnt_reg + 1'b1;
      assign rep_target   = rep_first_reg ? REP_W'(REPEAT_DELAY) : REP_W'(REPEAT_CNT);
      assign rep_fire[gi] = level[KI] & ~rise[KI] & (rep_cnt_inc == rep_target);

      always_ff @(posedge clk_db or negedge rst_n) begin
        if (!rst_n) begin
          rep_cnt_reg   <= '0;
          rep_first_reg <= 1'b1;
        end else if (!level[KI] || rise[KI]) begin
          rep_cnt_reg   <= '0;
          rep_first_reg <= 1'b1;
        end else if (rep_fire[gi]) begin
          rep_cnt_reg   <= '0;
          rep_first_reg <= 1'b0;
        end else begin
          rep_cnt_reg <= rep_cnt_inc;
        end
      end
    end
  endgenerate

  assign left_req  = rise[KEY_LEFT]  | rep_fire[0];
  assign right_req = rise[KEY_RIGHT] | rep_fire[1];
`else
  assign left_req  = rise[KEY_LEFT];
  assign right_req = rise[KEY_RIGHT];
`endif

  s2_state_t         state_reg;
  logic [HOLD_W-1:0] hold_cnt_reg;
  logic [HOLD_W-1:0] hold_cnt_inc;
  logic              s2_long_req;
  logic              s2_short_req;
  logic              btn_left_reg;
  logic              btn_right_reg;
  logic              s2_short_reg;
  logic              s2_long_reg;

  assign hold_cnt_inc = (hold_cnt_reg == HOLD_W'(LONG_CNT)) ? hold_cnt_reg : hold_cnt_reg + 1'b1;
  assign s2_long_req  = (state_reg == HELD) & level[KEY_MODE] & (hold_cnt_inc == HOLD_W'(LONG_CNT - 1));
  assign s2_short_req = (state_reg == HELD) & ~level[KEY_MODE];

  always_ff @(posedge clk_db or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      hold_cnt_reg  <= '0;
      btn_left_reg  <= 1'b0;
      btn_right_reg <= 1'b0;
      s2_short_reg  <= 1'b0;
      s2_long_reg   <= 1'b0;
    end else begin
      // Fixed priority; a losing request is simply dropped.
      btn_left_reg  <= left_req;
      btn_right_reg <= right_req & ~left_req;
      s2_long_reg   <= s2_long_req & ~left_req & ~right_req;
      s2_short_reg  <= s2_short_req & ~left_req & ~right_req & ~s2_long_req;

      case (state_reg)
        IDLE: begin
          if (rise[KEY_MODE]) begin
            hold_cnt_reg <= '0;
            state_reg    <= HELD;
          end
        end
        HELD: begin
          if (!level[KEY_MODE]) begin
            state_reg <= IDLE;
          end else begin
            hold_cnt_reg <= hold_cnt_inc;
            if (s2_long_req) begin
              state_reg <= LONG;
            end
          end
        end
        LONG: begin
          if (!level[KEY_MODE]) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign kif.btn_left  = btn_left_reg;
  assign kif.btn_right = btn_right_reg;
  assign kif.s2_short  = s2_short_reg;
  assign kif.s2_long   = s2_long_reg;
  assign kif.key_level = level;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed self-checking bench for key_conditioner with DEBOUNCE_CNT=4,
// LONG_CNT=20, REPEAT_DELAY=10, REPEAT_CNT=5.
module tb_key_conditioner;
  import key_pkg::*;

  logic clk_db = 1'b0;
  logic rst_n  = 1'b0;
  int   cyc    = 0;
  int   tests    = 0;
  int   failures = 0;

  int left_cnt, right_cnt, short_cnt, long_cnt, multi_cnt;
  int left_last, short_last, long_last;
  int right_q[$];
  int t, t0;
  int exp_rep[6];

  key_conditioner_if kif();

  key_conditioner #(
    .DEBOUNCE_CNT(4),
    .LONG_CNT    (20),
    .REPEAT_DELAY(10),
    .REPEAT_CNT  (5)
  ) dut (
    .clk_db(clk_db),
    .rst_n (rst_n),
    .kif   (kif)
  );

  always #5 clk_db = ~clk_db;

  always @(posedge clk_db) cyc <= cyc + 1;

  // Event monitor: sampled on the falling edge, cyc names the preceding rising edge.
  always @(negedge clk_db) begin
    int n;
    n = int'(kif.btn_left) + int'(kif.btn_right) + int'(kif.s2_short) + int'(kif.s2_long);
    if (n > 1) multi_cnt++;
    if (kif.btn_left === 1'b1) begin left_cnt++; left_last = cyc; end
    if (kif.btn_right === 1'b1) begin right_cnt++; right_q.push_back(cyc); end
    if (kif.s2_short === 1'b1) begin short_cnt++; short_last = cyc; end
    if (kif.s2_long === 1'b1) begin long_cnt++; long_last = cyc; end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_db);
  endtask

  task automatic clr_counts();
    left_cnt = 0; right_cnt = 0; short_cnt = 0; long_cnt = 0; multi_cnt = 0;
    left_last = -1; short_last = -1; long_last = -1;
    right_q.delete();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    clr_counts();
    kif.key_raw = '0;
    rst_n = 1'b0;
    tick(3);
    $display("[TB] step: reset state");
    chk("reset_pulses", {28'd0, kif.btn_left, kif.btn_right, kif.s2_short, kif.s2_long}, 32'd0);
    chk("reset_level", {29'd0, kif.key_level}, 32'd0);
    rst_n = 1'b1;
    tick(3);
    chk("idle_after_reset", left_cnt + right_cnt + short_cnt + long_cnt, 0);

    $display("[TB] step: S0 bounce then stable press");
    clr_counts();
    kif.key_raw[KEY_LEFT] = 1'b1; tick(2);
    kif.key_raw[KEY_LEFT] = 1'b0; tick(2);
    kif.key_raw[KEY_LEFT] = 1'b1; t = cyc;
    tick(10);
    chk("left_count", left_cnt, 1);
    chk("left_latency", left_last, t + 7);
    chk("left_level_high", {31'd0, kif.key_level[KEY_LEFT]}, 32'd1);
    kif.key_raw[KEY_LEFT] = 1'b0;
    tick(10);
    chk("left_level_low", {31'd0, kif.key_level[KEY_LEFT]}, 32'd0);
    chk("left_no_release_event", left_cnt, 1);

    $display("[TB] step: S2 short press");
    clr_counts();
    kif.key_raw[KEY_MODE] = 1'b1; tick(12);
    kif.key_raw[KEY_MODE] = 1'b0; t = cyc;
    tick(12);
    chk("short_count", short_cnt, 1);
    chk("short_latency", short_last, t + 7);
    chk("short_no_long", long_cnt, 0);

    $display("[TB] step: S2 long press");
    clr_counts();
    kif.key_raw[KEY_MODE] = 1'b1; t = cyc;
    tick(30);
    chk("long_level_high", {31'd0, kif.key_level[KEY_MODE]}, 32'd1);
    chk("long_count", long_cnt, 1);
    chk("long_latency", long_last, t + 26);
    kif.key_raw[KEY_MODE] = 1'b0;
    tick(12);
    chk("long_no_short", short_cnt, 0);
    chk("long_single", long_cnt, 1);

    $display("[TB] step: S0 and S3 together");
    clr_counts();
    kif.key_raw = 3'b101; t = cyc;
    tick(10);
    kif.key_raw = 3'b000;
    tick(12);
    chk("both_left_count", left_cnt, 1);
    chk("both_left_latency", left_last, t + 7);
    chk("both_right_dropped", right_cnt, 0);
    chk("both_one_pulse_per_cycle", multi_cnt, 0);

    $display("[TB] step: reset during S2 hold");
    clr_counts();
    kif.key_raw[KEY_MODE] = 1'b1;
    tick(22);
    rst_n = 1'b0;
    tick(1);
    chk("midreset_level", {29'd0, kif.key_level}, 32'd0);
    chk("midreset_long_out", {31'd0, kif.s2_long}, 32'd0);
    tick(2);
    rst_n = 1'b1; t = cyc;
    tick(30);
    chk("midreset_long_count", long_cnt, 1);
    chk("midreset_long_latency", long_last, t + 26);
    kif.key_raw[KEY_MODE] = 1'b0;
    tick(12);
    chk("midreset_no_short", short_cnt, 0);
    chk("midreset_no_buttons", left_cnt + right_cnt, 0);

    $display("[TB] step: S3 long hold");
    clr_counts();
    kif.key_raw[KEY_RIGHT] = 1'b1; t0 = cyc + 7;
    tick(33);
    kif.key_raw[KEY_RIGHT] = 1'b0;
    tick(15);
    chk("hold_no_left", left_cnt, 0);
`ifdef KEY_AUTO_REPEAT_EN
    exp_rep = '{0, 10, 15, 20, 25, 30};
    chk("repeat_count", right_cnt, 6);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("repeat_time_%0d", k), (k < right_q.size()) ? right_q[k] : -1, t0 + exp_rep[k]);
    end
`else
    chk("hold_single_right", right_cnt, 1);
    chk("hold_right_latency", (right_q.size() > 0) ? right_q[0] : -1, t0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
